// File: rtl/pulse_period_meter_pkg.sv
// Shared definitions for the pulse period meter: FSM state encoding and
// default classification windows / loss timeout (in clock cycles).
package pulse_period_meter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMeas = 2'd1,
    StLost = 2'd2
  } state_e;

  localparam int unsigned CntWidth   = 32;
  localparam int unsigned DefP1Min   = 49_000_000;
  localparam int unsigned DefP1Max   = 51_000_000;
  localparam int unsigned DefP2Min   = 24_000_000;
  localparam int unsigned DefP2Max   = 26_000_000;
  localparam int unsigned DefTimeout = 100_000_000;

endpackage

// File: rtl/pulse_period_meter_sync_edge.sv
// Two-flop synchronizer for the asynchronous pulse input followed by a
// rising-edge detector on the synchronized level.
module pulse_period_meter_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_edge
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
    end else begin
      r_sync1 <= i_async;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign o_edge = r_sync2 & ~r_prev;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures rising-to-rising period of a slow pulse in clock cycles, classifies
// it into a 1 Hz or 2 Hz window, and flags loss of the pulse after a timeout.
module pulse_period_meter
  import pulse_period_meter_pkg::*;
#(
  parameter int unsigned P1_MIN  = DefP1Min,
  parameter int unsigned P1_MAX  = DefP1Max,
  parameter int unsigned P2_MIN  = DefP2Min,
  parameter int unsigned P2_MAX  = DefP2Max,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_pulse,
  output logic [CntWidth-1:0] o_period,
  output logic                o_valid,
  output logic                o_mode,
  output logic                o_lock,
  output logic                o_lost
);

  logic w_edge;

  pulse_period_meter_sync_edge u_sync_edge (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_pulse),
    .o_edge  (w_edge)
  );

  state_e              r_state, w_state_next;
  logic [CntWidth-1:0] r_cnt, w_cnt_next;
  logic [CntWidth-1:0] r_period, w_period_next;
  logic                r_valid, w_valid_next;
  logic                r_mode, w_mode_next;
  logic                r_lock, w_lock_next;
  logic                r_lost, w_lost_next;

  logic w_in_p1;
  logic w_in_p2;
  logic w_timeout;

  // Window bounds are inclusive on both ends.
  assign w_in_p1   = (r_cnt >= CntWidth'(P1_MIN)) && (r_cnt <= CntWidth'(P1_MAX));
  assign w_in_p2   = (r_cnt >= CntWidth'(P2_MIN)) && (r_cnt <= CntWidth'(P2_MAX));
  assign w_timeout = (r_cnt == CntWidth'(TIMEOUT));

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_period_next = r_period;
    w_valid_next  = 1'b0;
    w_mode_next   = r_mode;
    w_lock_next   = r_lock;
    w_lost_next   = r_lost;
    case (r_state)
      StIdle: begin
        if (w_edge) begin
          w_state_next = StMeas;
          w_cnt_next   = CntWidth'(1);
        end
      end
      StMeas: begin
        // An edge in the timeout cycle still counts as a valid measurement.
        if (w_edge) begin
          w_period_next = r_cnt;
          w_valid_next  = 1'b1;
          w_mode_next   = w_in_p1;
          w_lock_next   = w_in_p1 | w_in_p2;
          w_cnt_next    = CntWidth'(1);
        end else if (w_timeout) begin
          w_state_next = StLost;
          w_lost_next  = 1'b1;
          w_lock_next  = 1'b0;
        end else begin
          w_cnt_next = r_cnt + CntWidth'(1);
        end
      end
      StLost: begin
        // The interval ending at the next edge started during the outage, so it only re-arms.
        if (w_edge) begin
          w_state_next = StMeas;
          w_cnt_next   = CntWidth'(1);
          w_lost_next  = 1'b0;
        end
      end
      default: begin
        w_state_next = StIdle;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_period <= '0;
      r_valid  <= 1'b0;
      r_mode   <= 1'b0;
      r_lock   <= 1'b0;
      r_lost   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_period <= w_period_next;
      r_valid  <= w_valid_next;
      r_mode   <= w_mode_next;
      r_lock   <= w_lock_next;
      r_lost   <= w_lost_next;
    end
  end

  assign o_period = r_period;
  assign o_valid  = r_valid;
  assign o_mode   = r_mode;
  assign o_lock   = r_lock;
  assign o_lost   = r_lost;

endmodule

// File: doc/pulse_period_meter.md
PULSE_PERIOD_METER -- requirements
Module: pulse_period_meter

Interface
REQ-001 Parameter P1_MIN, default 49_000_000, lower period bound in I_CLK cycles for 1 Hz class.
REQ-002 Parameter P1_MAX, default 51_000_000, upper bound for 1 Hz class.
REQ-003 Parameter P2_MIN, default 24_000_000, lower bound for 2 Hz class.
REQ-004 Parameter P2_MAX, default 26_000_000, upper bound for 2 Hz class.
REQ-005 Parameter TIMEOUT, default 100_000_000, cycles without a rising edge before loss is declared.
REQ-006 I_CLK  input  1  sole clock, all logic on rising edge.
REQ-007 I_RST  input  1  reset, synchronous, active-high.
REQ-008 I_PULSE  input  1  asynchronous slow square wave from the pulse divider.
REQ-009 O_PERIOD  output  32  last measured rising-to-rising period in I_CLK cycles.
REQ-010 O_VALID  output  1  one-cycle strobe, O_PERIOD/O_MODE/O_LOCK updated.
REQ-011 O_MODE  output  1  1 = last period in 1 Hz window, 0 otherwise.
REQ-012 O_LOCK  output  1  last period fell inside either window.
REQ-013 O_LOST  output  1  no rising edge for TIMEOUT cycles; level, not strobe.

Function
REQ-014 I_PULSE SHALL pass a 2-flop synchronizer, then a previous-value register; rising edge = sync2 & ~prev.
REQ-015 States: IDLE (no edge yet), MEAS (counting since last edge), LOST.
REQ-016 IDLE: on edge -> MEAS, CNT<=1, no O_VALID.
REQ-017 MEAS, no edge: CNT<=CNT+1.
REQ-018 MEAS, edge: O_PERIOD<=CNT, O_VALID<=1 next cycle, classification from CNT, CNT<=1, stay MEAS.
REQ-019 Period k SHALL equal the number of I_CLK cycles between the two edge-detect cycles.
REQ-020 Classification: O_MODE=1,O_LOCK=1 if P1_MIN<=CNT<=P1_MAX; O_MODE=0,O_LOCK=1 if P2_MIN<=CNT<=P2_MAX; else O_MODE=0,O_LOCK=0; bounds inclusive.
REQ-021 MEAS, CNT==TIMEOUT and no edge same cycle -> LOST, O_LOST<=1, O_LOCK<=0, O_PERIOD held; edge in that cycle wins (measure, no loss).
REQ-022 LOST: CNT frozen; on edge -> MEAS, CNT<=1, O_LOST<=0, no O_VALID (first interval after loss is not measured).
REQ-023 O_VALID latency: high for exactly the cycle following the 3rd I_CLK rising edge, counting the edge that first samples I_PULSE high.
REQ-024 CNT 32-bit unsigned; TIMEOUT < 2^32 guarantees no wrap.
REQ-025 O_PERIOD, O_MODE, O_LOCK SHALL hold between strobes.

Reset
REQ-026 I_RST high: state IDLE, CNT=0, synchronizer and prev regs 0, O_PERIOD=0, O_VALID=0, O_MODE=0, O_LOCK=0, O_LOST=0.
REQ-027 Reset asserted mid-measurement SHALL discard the partial count; first edge after release only arms (IDLE->MEAS).
REQ-028 No initial-block dependence; reset alone defines state.

Structure
REQ-029 Shared package holds state encoding (IDLE/MEAS/LOST, 2 bits) and default window/timeout constants.
REQ-030 One sub-module: sync_edge (2-flop synchronizer plus rising-edge detector); FSM, counter, classifier in top.

Verification (P1=90..110, P2=45..55, TIMEOUT=250)
REQ-031 Reset, then I_PULSE period 100 cycles -> first edge no strobe; each later edge: O_PERIOD=100, O_MODE=1, O_LOCK=1, O_VALID one cycle.
REQ-032 Period 50 -> O_PERIOD=50, O_MODE=0, O_LOCK=1; switch to 100 mid-stream -> next strobe reports the actual mixed interval, then 100/MODE=1.
REQ-033 Period 70 -> O_PERIOD=70, O_LOCK=0, O_MODE=0; boundary periods 45, 55, 90, 110 -> O_LOCK=1; 44, 111 -> O_LOCK=0.
REQ-034 Stop I_PULSE after edge -> O_LOST=1 exactly 250 cycles after last edge-detect, O_LOCK=0; resume -> O_LOST clears on first edge, no strobe, next edge strobes.
REQ-035 Edge coincident with CNT==250 -> O_VALID with O_PERIOD=250, O_LOST stays 0.
REQ-036 I_RST pulsed mid-period -> all outputs 0 next cycle; next edge no strobe; following edge measures correctly.
